// File: rtl/arb_merge_pkg.sv
// arb_merge_pkg: shared state encoding and default payload width for the two-source merge arbiter
package arb_merge_pkg;
  localparam int DATA_WIDTH_DEF = 32;
  typedef enum logic {IDLE, WAIT} state_t;
endpackage

// File: rtl/hold_slot.sv
// hold_slot: one-deep request slot holding a pending flag and its captured payload
module hold_slot import arb_merge_pkg::*; #(
  parameter int W = DATA_WIDTH_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         drive,
  input  logic         clr,
  input  logic [W-1:0] data,
  output logic         pend,
  output logic [W-1:0] payload,
  output logic         viol
);
  assign viol = drive & pend;
  always_ff @(posedge clk) begin
    if (rst) begin
      pend    <= 1'b0;
      payload <= '0;
    end else if (drive && !pend) begin
      pend    <= 1'b1;
      payload <= data;
    end else if (clr) begin
      pend    <= 1'b0;
    end
  end
endmodule

// File: rtl/arb_merge_2_d.sv
// arb_merge_2_d: round-robin merge of two pulse-handshake sources onto one downstream stage
module arb_merge_2_d import arb_merge_pkg::*; #(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_drive0,
  input  logic [DATA_WIDTH-1:0] i_data0,
  output logic                  o_free0,
  input  logic                  i_drive1,
  input  logic [DATA_WIDTH-1:0] i_data1,
  output logic                  o_free1,
  output logic                  o_driveNext,
  input  logic                  i_freeNext,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_src,
  output logic                  o_busy,
  output logic                  o_err
);
  state_t state, state_n;
  logic pend0, pend1, viol0, viol1;
  logic [DATA_WIDTH-1:0] reg0, reg1;
  logic w, last, first, err, sel, rel, any;
  logic [1:0] free;
  assign any = pend0 | pend1;
  assign sel = (pend0 & pend1) ? !last : pend1;
  assign rel = (state == WAIT) & i_freeNext;
  hold_slot #(.W(DATA_WIDTH)) u_slot0 (
    .clk(clk), .rst(rst), .drive(i_drive0), .clr(rel & !w), .data(i_data0),
    .pend(pend0), .payload(reg0), .viol(viol0)
  );
  hold_slot #(.W(DATA_WIDTH)) u_slot1 (
    .clk(clk), .rst(rst), .drive(i_drive1), .clr(rel & w), .data(i_data1),
    .pend(pend1), .payload(reg1), .viol(viol1)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      w     <= 1'b0;
      last  <= 1'b1;
      first <= 1'b0;
      err   <= 1'b0;
      free  <= 2'b00;
    end else begin
      state <= state_n;
      first <= (state == IDLE) & any;
      if (state == IDLE && any) w <= sel;
      if (rel) last <= w;
      free  <= rel ? (w ? 2'b10 : 2'b01) : 2'b00;
      err   <= err | viol0 | viol1 | ((state == IDLE) & i_freeNext);
    end
  end
  // every output is forced low during reset cycles, including a grant being aborted
  always_comb begin
    state_n     = state;
    state_n     = (state == IDLE) ? (any ? WAIT : IDLE) : (i_freeNext ? IDLE : WAIT);
    o_busy      = !rst && state == WAIT;
    o_driveNext = o_busy && first;
    o_src       = o_busy && w;
    o_data      = o_busy ? (w ? reg1 : reg0) : '0;
    o_free0     = !rst && free[0];
    o_free1     = !rst && free[1];
    o_err       = !rst && err;
  end
endmodule
